multicycle_alu: RTL and testbench

Multi-cycle integer ALU for the nano-cpu core. It sits behind the processor's `in_valid`/`out_valid` ALU handshake: it captures `rs1` and the operand-B value on a one-cycle request and computes the RV32I integer op selected by `op_in` over several cycles. It returns the result with a one-cycle `out_valid` pulse, which the processor uses as its register-file write enable and PC-advance strobe.

---
 rtl/alu_pkg.sv | 33 +++
 rtl/alu_chunk_adder.sv | 27 ++
 rtl/multicycle_alu.sv | 153 +++++++++++++++
 tb/tb_multicycle_alu.sv | 148 ++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared ALU definitions: funct3 encodings, op bundle and FSM states.
// The op typedef is also used by the processor decode stage.
package alu_pkg;

  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_SRL  = 3'b101;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;

  localparam int unsigned ALT_BIT = 3;

  typedef struct packed {
    logic       alt;
    logic [2:0] funct3;
  } alu_op_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ARITH,
    ST_SHIFT,
    ST_DONE
  } alu_state_t;

  // SUB, SLT and SLTU all run the adder as a + ~b + 1.
  function automatic logic op_is_sub(input alu_op_t op);
    return (op.funct3 == F3_ADD && op.alt) || op.funct3 == F3_SLT || op.funct3 == F3_SLTU;
  endfunction

endpackage

// File: rtl/alu_chunk_adder.sv
// Combinational CHUNK-bit adder slice with optional B inversion,
// carry in/out and the MSB taps needed for signed compare.
module alu_chunk_adder #(
  parameter int CHUNK = 8
) (
  input  logic [CHUNK-1:0] a_in,
  input  logic [CHUNK-1:0] b_in,
  input  logic             sub_in,
  input  logic             cin,
  output logic [CHUNK-1:0] sum,
  output logic             cout,
  output logic             a_msb,
  output logic             b_msb,
  output logic             sum_msb
);

  logic [CHUNK-1:0] b_eff;

  always_comb begin
    b_eff       = sub_in ? ~b_in : b_in;
    {cout, sum} = {1'b0, a_in} + {1'b0, b_eff} + {{CHUNK{1'b0}}, cin};
    a_msb       = a_in[CHUNK-1];
    b_msb       = b_in[CHUNK-1];
    sum_msb     = sum[CHUNK-1];
  end

endmodule

// File: rtl/multicycle_alu.sv
// Multi-cycle RV32I integer ALU: chunked ripple add, 1-bit/cycle shifter,
// single-cycle logic ops, one-cycle out_valid result strobe.
module multicycle_alu
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic [3:0]       op_in,
  input  logic             in_valid,
  output logic [WIDTH-1:0] out,
  output logic             out_valid,
  output logic             busy
);

  localparam int unsigned NCHUNK = WIDTH / CHUNK;
  localparam int unsigned SHW    = $clog2(WIDTH);
  localparam int unsigned CW     = SHW + 1;

  alu_state_t       state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, sum_q, sum_d, out_q, out_d;
  alu_op_t          op_q, op_d, op_new;
  logic             carry_q, carry_d, lt_q, lt_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             out_valid_q, out_valid_d, busy_q, busy_d;
  logic             accept;

  logic [CHUNK-1:0] add_sum;
  logic             add_cout, add_a_msb, add_b_msb, add_sum_msb;

  alu_chunk_adder #(.CHUNK(CHUNK)) u_adder (
    .a_in    (a_q[CHUNK-1:0]),
    .b_in    (b_q[CHUNK-1:0]),
    .sub_in  (op_is_sub(op_q)),
    .cin     (carry_q),
    .sum     (add_sum),
    .cout    (add_cout),
    .a_msb   (add_a_msb),
    .b_msb   (add_b_msb),
    .sum_msb (add_sum_msb)
  );

  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    op_d        = op_q;
    sum_d       = sum_q;
    carry_d     = carry_q;
    lt_d        = lt_q;
    cnt_d       = cnt_q;
    out_d       = out_q;
    out_valid_d = 1'b0;
    busy_d      = (state_q != ST_IDLE);
    op_new      = '{alt: op_in[ALT_BIT], funct3: op_in[2:0]};
    accept      = in_valid && (state_q == ST_IDLE) && !busy_q;

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          a_d     = a_in;
          b_d     = b_in;
          op_d    = op_new;
          busy_d  = 1'b1;
          carry_d = op_is_sub(op_new);
          sum_d   = '0;
          lt_d    = 1'b0;
          case (op_new.funct3)
            F3_ADD, F3_SLT, F3_SLTU: begin
              cnt_d   = CW'(NCHUNK);
              state_d = ST_ARITH;
            end
            F3_SLL, F3_SRL: begin
              cnt_d   = {1'b0, b_in[SHW-1:0]};
              state_d = (b_in[SHW-1:0] == '0) ? ST_DONE : ST_SHIFT;
            end
            default: state_d = ST_DONE;
          endcase
        end
      end
      ST_ARITH: begin
        // Operands rotate right one slice per cycle, so after the final
        // slice a_q/b_q are back to their captured values.
        a_d     = {a_q[CHUNK-1:0], a_q[WIDTH-1:CHUNK]};
        b_d     = {b_q[CHUNK-1:0], b_q[WIDTH-1:CHUNK]};
        sum_d   = {add_sum, sum_q[WIDTH-1:CHUNK]};
        carry_d = add_cout;
        cnt_d   = cnt_q - 1'b1;
        if (cnt_q == CW'(1)) begin
          lt_d    = (add_a_msb ^ add_b_msb) ? add_a_msb : add_sum_msb;
          state_d = ST_DONE;
        end
      end
      ST_SHIFT: begin
        if (op_q.funct3 == F3_SLL) a_d = {a_q[WIDTH-2:0], 1'b0};
        else                       a_d = {op_q.alt & a_q[WIDTH-1], a_q[WIDTH-1:1]};
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CW'(1)) state_d = ST_DONE;
      end
      ST_DONE: begin
        out_valid_d = 1'b1;
        state_d     = ST_IDLE;
        case (op_q.funct3)
          F3_ADD:         out_d = sum_q;
          F3_SLT:         out_d = {{(WIDTH-1){1'b0}}, lt_q};
          F3_SLTU:        out_d = {{(WIDTH-1){1'b0}}, ~carry_q};
          F3_SLL, F3_SRL: out_d = a_q;
          F3_XOR:         out_d = a_q ^ b_q;
          F3_OR:          out_d = a_q | b_q;
          default:        out_d = a_q & b_q;
        endcase
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      a_q         <= '0;
      b_q         <= '0;
      op_q        <= '0;
      sum_q       <= '0;
      carry_q     <= 1'b0;
      lt_q        <= 1'b0;
      cnt_q       <= '0;
      out_q       <= '0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      op_q        <= op_d;
      sum_q       <= sum_d;
      carry_q     <= carry_d;
      lt_q        <= lt_d;
      cnt_q       <= cnt_d;
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
    end
  end

  assign out       = out_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_multicycle_alu.sv
// Directed table-driven bench for multicycle_alu: result, latency, busy
// window, single-pulse handshake, ignored re-requests and mid-op reset.
module tb_multicycle_alu;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] a_in, b_in;
  logic [3:0]  op_in;
  logic        in_valid;
  logic [31:0] out;
  logic        out_valid;
  logic        busy;

  int n_cmp = 0;
  int n_bad = 0;

  multicycle_alu #(.WIDTH(32), .CHUNK(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .a_in      (a_in),
    .b_in      (b_in),
    .op_in     (op_in),
    .in_valid  (in_valid),
    .out       (out),
    .out_valid (out_valid),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  op;
    int          hold;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic run_op(input vec_t v);
    int got_lat;
    int pulses;
    logic [31:0] got_out;
    got_lat = 0;
    pulses  = 0;
    got_out = '0;
    @(negedge clk);
    chk({v.name, " busy_idle"}, {31'b0, busy}, 32'd0);
    a_in = v.a; b_in = v.b; op_in = v.op; in_valid = 1'b1;
    @(posedge clk); #1;
    a_in = ~v.a; b_in = ~v.b;
    if (v.hold == 0) in_valid = 1'b0;
    chk({v.name, " busy_rise"}, {31'b0, busy}, 32'd1);
    for (int k = 1; k <= 80; k++) begin
      @(posedge clk); #1;
      if (k >= v.hold) in_valid = 1'b0;
      if (out_valid) begin
        pulses++;
        if (got_lat == 0) begin
          got_lat = k;
          got_out = out;
          chk({v.name, " busy_at_pulse"}, {31'b0, busy}, 32'd1);
        end
      end
      if (got_lat != 0 && k == got_lat + 1) begin
        chk({v.name, " busy_fall"}, {31'b0, busy}, 32'd0);
        chk({v.name, " out_held"}, out, v.exp);
      end
      if (got_lat != 0 && k == got_lat + 6) break;
    end
    chk({v.name, " latency"}, got_lat, v.lat);
    chk({v.name, " pulses"}, pulses, 32'd1);
    chk({v.name, " out"}, got_out, v.exp);
  endtask

  initial begin
    int pulses;
    vec_t v;

    vecs.push_back('{"add",       32'd5,         32'd7,         4'b0000, 0, 32'd12,         5});
    vecs.push_back('{"sub",       32'd0,         32'd1,         4'b1000, 0, 32'hFFFF_FFFF,  5});
    vecs.push_back('{"add_wrap",  32'hFFFF_FFFF, 32'd1,         4'b0000, 0, 32'd0,          5});
    vecs.push_back('{"sub_10_3",  32'd10,        32'd3,         4'b1000, 0, 32'd7,          5});
    vecs.push_back('{"sra31",     32'h8000_0000, 32'd31,        4'b1101, 0, 32'hFFFF_FFFF, 32});
    vecs.push_back('{"srl31",     32'h8000_0000, 32'd31,        4'b0101, 0, 32'd1,         32});
    vecs.push_back('{"sll5",      32'd1,         32'h25,        4'b0001, 0, 32'h20,         6});
    vecs.push_back('{"sll0",      32'h1234_5678, 32'h40,        4'b0001, 0, 32'h1234_5678,  1});
    vecs.push_back('{"slt",       32'hFFFF_FFFF, 32'd1,         4'b0010, 0, 32'd1,          5});
    vecs.push_back('{"sltu",      32'hFFFF_FFFF, 32'd1,         4'b0011, 0, 32'd0,          5});
    vecs.push_back('{"slt_rev",   32'd1,         32'hFFFF_FFFF, 4'b0010, 0, 32'd0,          5});
    vecs.push_back('{"sltu_rev",  32'd1,         32'hFFFF_FFFF, 4'b0011, 0, 32'd1,          5});
    vecs.push_back('{"xor",       32'hF0,        32'hFF,        4'b0100, 0, 32'h0F,         1});
    vecs.push_back('{"xor_alt",   32'hF0,        32'hFF,        4'b1100, 0, 32'h0F,         1});
    vecs.push_back('{"or",        32'hF0F0,      32'h0FF0,      4'b0110, 0, 32'hFFF0,       1});
    vecs.push_back('{"and",       32'hF0F0,      32'h0FF0,      4'b0111, 0, 32'h00F0,       1});
    vecs.push_back('{"add_hold",  32'h1000,      32'h0234,      4'b0000, 5, 32'h1234,       5});

    rst = 1'b1; in_valid = 1'b0; a_in = '0; b_in = '0; op_in = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst out", out, 32'd0);
    chk("rst out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst busy", {31'b0, busy}, 32'd0);
    @(negedge clk); rst = 1'b0;
    repeat (2) @(posedge clk);

    foreach (vecs[i]) run_op(vecs[i]);

    // Reset in the middle of a 20-step SRA.
    @(negedge clk);
    a_in = 32'h8000_0000; b_in = 32'd20; op_in = 4'b1101; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    chk("mid_sra busy", {31'b0, busy}, 32'd1);
    rst = 1'b1;
    #1;
    chk("abort out", out, 32'd0);
    chk("abort out_valid", {31'b0, out_valid}, 32'd0);
    chk("abort busy", {31'b0, busy}, 32'd0);
    @(negedge clk); rst = 1'b0;
    pulses = 0;
    for (int k = 0; k < 30; k++) begin
      @(posedge clk); #1;
      if (out_valid) pulses++;
    end
    chk("abort late_pulse", pulses, 32'd0);

    v = '{"add_after_rst", 32'd2, 32'd3, 4'b0000, 0, 32'd5, 5};
    run_op(v);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
